// File: rtl/vga_timing_pattern_gen.sv
// VGA pixel-clock divider, H/V timing generator and test-pattern source.
// Pattern and colour selects are captured at pixel (0,0) so frames never tear.
module vga_timing_pattern_gen #(
  parameter int H_ACTIVE   = 640,
  parameter int H_FP       = 16,
  parameter int H_SYNC     = 96,
  parameter int H_BP       = 48,
  parameter int V_ACTIVE   = 480,
  parameter int V_FP       = 10,
  parameter int V_SYNC     = 2,
  parameter int V_BP       = 33,
  parameter int CLK_DIV    = 4,
  parameter int COLOR_W    = 4,
  parameter int HSYNC_POL  = 0,
  parameter int VSYNC_POL  = 0,
  parameter int CHK_LOG2   = 5,
  parameter int GRAD_SHIFT = 5,
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP,
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP,
  localparam int H_W     = $clog2(H_TOTAL),
  localparam int V_W     = $clog2(V_TOTAL)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [2:0]         controllers,
  input  logic [1:0]         mode_sel,
  output logic               hsync,
  output logic               vsync,
  output logic               de,
  output logic [COLOR_W-1:0] red,
  output logic [COLOR_W-1:0] green,
  output logic [COLOR_W-1:0] blue,
  output logic [H_W-1:0]     x,
  output logic [V_W-1:0]     y,
  output logic               frame_start
);

  typedef enum logic [1:0] {
    M_SOLID = 2'd0,
    M_BARS  = 2'd1,
    M_CHECK = 2'd2,
    M_GRAD  = 2'd3
  } mode_e;

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [H_W-1:0] H_LAST = H_W'(H_TOTAL - 1);
  localparam logic [V_W-1:0] V_LAST = V_W'(V_TOTAL - 1);
  localparam int H_SS  = H_ACTIVE + H_FP;
  localparam int H_SE  = H_SS + H_SYNC;
  localparam int V_SS  = V_ACTIVE + V_FP;
  localparam int V_SE  = V_SS + V_SYNC;
  localparam int BAR_W = (H_ACTIVE >= 8) ? H_ACTIVE / 8 : 1;
  localparam logic HS_ACT = (HSYNC_POL != 0);
  localparam logic VS_ACT = (VSYNC_POL != 0);

  logic [DIV_W-1:0]   div_q, div_d;
  logic [H_W-1:0]     h_cnt_q, h_cnt_d;
  logic [V_W-1:0]     v_cnt_q, v_cnt_d;
  mode_e              mode_q, mode_d;
  logic [2:0]         ctrl_q, ctrl_d;
  logic               hsync_q, hsync_d;
  logic               vsync_q, vsync_d;
  logic               de_q, de_d;
  logic [COLOR_W-1:0] red_q, red_d;
  logic [COLOR_W-1:0] green_q, green_d;
  logic [COLOR_W-1:0] blue_q, blue_d;
  logic [H_W-1:0]     x_q, x_d;
  logic [V_W-1:0]     y_q, y_d;
  logic               frame_start_q, frame_start_d;

  logic               tick;
  logic               frame0;
  logic [31:0]        hx, vx;
  logic [31:0]        bar_idx;
  logic [2:0]         bar_lvl;
  logic [2:0]         bar_rgb;
  logic               chk_sq;
  logic               de_pix;
  logic               hs_pix;
  logic               vs_pix;
  logic [COLOR_W-1:0] r_pix, g_pix, b_pix;

  assign tick   = (div_q == DIV_LAST);
  assign frame0 = (h_cnt_q == '0) && (v_cnt_q == '0);
  assign hx     = 32'(h_cnt_q);
  assign vx     = 32'(v_cnt_q);

  always_comb begin
    div_d   = tick ? '0 : div_q + DIV_W'(1);
    h_cnt_d = h_cnt_q;
    v_cnt_d = v_cnt_q;
    if (tick) begin
      if (h_cnt_q == H_LAST) begin
        h_cnt_d = '0;
        v_cnt_d = (v_cnt_q == V_LAST) ? '0 : v_cnt_q + V_W'(1);
      end else begin
        h_cnt_d = h_cnt_q + H_W'(1);
      end
    end
  end

  // (0,0) uses the freshly sampled selects, so decode from the _d values.
  always_comb begin
    mode_d = mode_q;
    ctrl_d = ctrl_q;
    if (tick && frame0) begin
      mode_d = mode_e'(mode_sel);
      ctrl_d = controllers;
    end
  end

  always_comb begin
    de_pix  = (hx < H_ACTIVE) && (vx < V_ACTIVE);
    hs_pix  = ((hx >= H_SS) && (hx < H_SE)) ? HS_ACT : ~HS_ACT;
    vs_pix  = ((vx >= V_SS) && (vx < V_SE)) ? VS_ACT : ~VS_ACT;
    bar_idx = hx / BAR_W;
    bar_lvl = (bar_idx > 32'd7) ? 3'd7 : bar_idx[2:0];
    bar_rgb = ~bar_lvl;
    chk_sq  = hx[CHK_LOG2] ^ vx[CHK_LOG2];
  end

  always_comb begin
    r_pix = '0;
    g_pix = '0;
    b_pix = '0;
    unique case (1'b1)
      (mode_d == M_SOLID): begin
        r_pix = {COLOR_W{ctrl_d[2]}};
        g_pix = {COLOR_W{ctrl_d[1]}};
        b_pix = {COLOR_W{ctrl_d[0]}};
      end
      (mode_d == M_BARS): begin
        r_pix = {COLOR_W{bar_rgb[2]}};
        g_pix = {COLOR_W{bar_rgb[1]}};
        b_pix = {COLOR_W{bar_rgb[0]}};
      end
      (mode_d == M_CHECK): begin
        if (!chk_sq) begin
          r_pix = {COLOR_W{ctrl_d[2]}};
          g_pix = {COLOR_W{ctrl_d[1]}};
          b_pix = {COLOR_W{ctrl_d[0]}};
        end
      end
      (mode_d == M_GRAD): begin
        r_pix = hx[GRAD_SHIFT +: COLOR_W];
        g_pix = vx[GRAD_SHIFT +: COLOR_W];
        b_pix = {COLOR_W{ctrl_d[0]}};
      end
      default: begin
        r_pix = '0;
      end
    endcase
    if (!de_pix) begin
      r_pix = '0;
      g_pix = '0;
      b_pix = '0;
    end
  end

  always_comb begin
    hsync_d       = tick ? hs_pix  : hsync_q;
    vsync_d       = tick ? vs_pix  : vsync_q;
    de_d          = tick ? de_pix  : de_q;
    red_d         = tick ? r_pix   : red_q;
    green_d       = tick ? g_pix   : green_q;
    blue_d        = tick ? b_pix   : blue_q;
    x_d           = tick ? h_cnt_q : x_q;
    y_d           = tick ? v_cnt_q : y_q;
    frame_start_d = tick && frame0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      div_q         <= '0;
      h_cnt_q       <= '0;
      v_cnt_q       <= '0;
      mode_q        <= M_SOLID;
      ctrl_q        <= 3'b000;
      hsync_q       <= ~HS_ACT;
      vsync_q       <= ~VS_ACT;
      de_q          <= 1'b0;
      red_q         <= '0;
      green_q       <= '0;
      blue_q        <= '0;
      x_q           <= '0;
      y_q           <= '0;
      frame_start_q <= 1'b0;
    end else begin
      div_q         <= div_d;
      h_cnt_q       <= h_cnt_d;
      v_cnt_q       <= v_cnt_d;
      mode_q        <= mode_d;
      ctrl_q        <= ctrl_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      de_q          <= de_d;
      red_q         <= red_d;
      green_q       <= green_d;
      blue_q        <= blue_d;
      x_q           <= x_d;
      y_q           <= y_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign de          = de_q;
  assign red         = red_q;
  assign green       = green_q;
  assign blue        = blue_q;
  assign x           = x_q;
  assign y           = y_q;
  assign frame_start = frame_start_q;

endmodule
